// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the mult_arbiter slice: FSM state encoding,
// requester-index width helper and default parameter values.
package mult_arb_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_LAT   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Requester-index width; a single requester still gets a 1-bit id.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Operand-request and result handshake bundle between requesters/consumer
// (master side) and the shared-multiplier arbiter (slave side).
interface mult_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
);
  localparam int IDW = idw(NREQ);

  logic [NREQ-1:0]       ireq_valid;
  logic [NREQ*WIDTH-1:0] ireq_a;
  logic [NREQ*WIDTH-1:0] ireq_b;
  logic [NREQ-1:0]       oreq_ready;
  logic [2*WIDTH-1:0]    ores;
  logic [IDW-1:0]        ores_id;
  logic                  ores_valid;
  logic                  ires_ready;
  logic                  obusy;

  modport master (
    output ireq_valid, ireq_a, ireq_b, ires_ready,
    input  oreq_ready, ores, ores_id, ores_valid, obusy
  );

  modport slave (
    input  ireq_valid, ireq_a, ireq_b, ires_ready,
    output oreq_ready, ores, ores_id, ores_valid, obusy
  );

endinterface

// File: rtl/mult_arbiter_core.sv
// mult_core: unsigned WIDTH x WIDTH multiplier, product and valid appear LAT
// cycles after the istart cycle.
module mult_core
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic               iclk,
  input  logic               irst,
  input  logic [WIDTH-1:0]   ia,
  input  logic [WIDTH-1:0]   ib,
  input  logic               istart,
  output logic [2*WIDTH-1:0] ores,
  output logic               ovalid
);

  logic [2*WIDTH-1:0] prod_q [LAT];
  logic [LAT-1:0]     vld_q;
  logic [2*WIDTH-1:0] wa;
  logic [2*WIDTH-1:0] wb;

  // Widen before multiplying so the full 2*WIDTH product is kept.
  assign wa = {{WIDTH{1'b0}}, ia};
  assign wb = {{WIDTH{1'b0}}, ib};

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= istart;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // NOTE: the product pipeline carries no reset; only the valid bits need
  // one, and leaving data unreset keeps it out of the reset tree.
  always_ff @(posedge iclk) begin
    prod_q[0] <= wa * wb;
    for (int i = 1; i < LAT; i++) prod_q[i] <= prod_q[i-1];
  end

  assign ores   = prod_q[LAT-1];
  assign ovalid = vld_q[LAT-1];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one mult_core among NREQ requesters.
// Define MULT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int LAT   = DEF_LAT
) (
  input  logic          iclk,
  input  logic          irst,
  mult_arbiter_if.slave bus
);

  localparam int IDW = idw(NREQ);
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic               found;
  logic [IDW-1:0]     win;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               core_start;
  logic [2*WIDTH-1:0] core_res;
  logic               core_valid;

`ifdef MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.ireq_valid[i]) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] rot;

  // Rotate so bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    rot   = NREQ'({bus.ireq_valid, bus.ireq_valid} >> ptr_q);
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end
`endif

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        op_a = bus.ireq_a[i*WIDTH +: WIDTH];
        op_b = bus.ireq_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gid_d          = gid_q;
    id_d           = id_q;
    res_d          = res_q;
    core_start     = 1'b0;
    bus.oreq_ready = '0;
`ifndef MULT_ARB_FIXED_PRIO_EN
    ptr_d          = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found && !irst) begin
          bus.oreq_ready = NREQ'(1) << win;
          core_start     = 1'b1;
          gid_d          = win;
          cnt_d          = CNT_LOAD;
          state_d        = CALC;
`ifndef MULT_ARB_FIXED_PRIO_EN
          ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
`endif
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          res_d   = core_res;
          id_d    = gid_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (bus.ires_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the comb block above uses blocking ones.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gid_q   <= '0;
      id_q    <= '0;
      res_q   <= '0;
`ifndef MULT_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      id_q    <= id_d;
      res_q   <= res_d;
`ifndef MULT_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.ores       = res_q;
  assign bus.ores_id    = id_q;
  assign bus.ores_valid = (state_q == DONE);
  assign bus.obusy      = (state_q != IDLE);

  mult_core #(.WIDTH(WIDTH), .LAT(LAT)) u_core (
    .iclk   (iclk),
    .irst   (irst),
    .ia     (op_a),
    .ib     (op_b),
    .istart (core_start),
    .ores   (core_res),
    .ovalid (core_valid)
  );

  // The countdown and the core pipeline must agree on when the product lands.
  a_core_sync: assert property (@(posedge iclk) disable iff (irst)
    (state_q == CALC && cnt_q == '0) |-> core_valid);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed cases plus random traffic
// checked cycle by cycle against a transaction-timeline reference model.
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  localparam int WIDTH = 5;
  localparam int NREQ  = 4;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  mult_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .iclk (clk),
    .irst (rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus state
  bit [NREQ-1:0] vld_v;
  int            a_v [NREQ];
  int            b_v [NREQ];
  bit            rdy_v;

  // Reference model: one outstanding job, result due LAT+1 cycles after grant
  bit m_busy;
  int m_gcyc, m_res, m_id, m_ptr;
  int cyc;
  int dut_grants [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input bit [NREQ-1:0] v, input int p);
`ifdef MULT_ARB_FIXED_PRIO_EN
    p = 0;
`endif
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  task automatic drive();
    bus.ireq_valid = vld_v;
    bus.ires_ready = rdy_v;
    for (int k = 0; k < NREQ; k++) begin
      bus.ireq_a[k*WIDTH +: WIDTH] = WIDTH'(a_v[k]);
      bus.ireq_b[k*WIDTH +: WIDTH] = WIDTH'(b_v[k]);
    end
  endtask

  // One clock cycle: drive, sample at negedge, check, advance model.
  task automatic step();
    int            w;
    bit [NREQ-1:0] exp_rdy;
    bit            exp_v;
    drive();
    @(negedge clk);
    for (int k = 0; k < NREQ; k++)
      if (bus.oreq_ready[k] === 1'b1) dut_grants.push_back(k);
    if (!m_busy) begin
      w       = pick(vld_v, m_ptr);
      exp_rdy = (w >= 0) ? (NREQ'(1) << w) : '0;
      check("grant_vec", 32'(bus.oreq_ready), 32'(exp_rdy));
      check("idle_busy", 32'(bus.obusy), 0);
      check("idle_valid", 32'(bus.ores_valid), 0);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_gcyc = cyc;
        m_res  = a_v[w] * b_v[w];
        m_id   = w;
        m_ptr  = (w + 1) % NREQ;
      end
    end else begin
      check("busy_grant_vec", 32'(bus.oreq_ready), 0);
      check("busy_flag", 32'(bus.obusy), 1);
      exp_v = (cyc >= m_gcyc + LAT + 1);
      check("res_valid", 32'(bus.ores_valid), 32'(exp_v));
      if (exp_v) begin
        check("res", 32'(bus.ores), m_res);
        check("res_id", 32'(bus.ores_id), m_id);
        if (rdy_v) m_busy = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && m_busy; i++) step();
    check("idle_reached", 32'(bus.obusy), 0);
  endtask

  // Asynchronous reset pulse asserted mid-cycle; outputs must clear at once.
  task automatic pulse_reset(input int hold);
    drive();
    rst = 1'b1;
    #1;
    check("rst_grant_vec", 32'(bus.oreq_ready), 0);
    check("rst_valid", 32'(bus.ores_valid), 0);
    check("rst_res", 32'(bus.ores), 0);
    check("rst_res_id", 32'(bus.ores_id), 0);
    check("rst_busy", 32'(bus.obusy), 0);
    m_busy = 1'b0;
    m_ptr  = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rst_hold_valid", 32'(bus.ores_valid), 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic single(input int idx, input int a, input int b, input int exp_prod);
    vld_v = '0;
    rdy_v = 1'b1;
    wait_idle();
    dut_grants.delete();
    vld_v      = NREQ'(1) << idx;
    a_v[idx]   = a;
    b_v[idx]   = b;
    rdy_v      = 1'b0;
    step();
    vld_v = '0;
    step();
    step();
    check($sformatf("prod_%0dx%0d", a, b), 32'(bus.ores), exp_prod);
    check("prod_id", 32'(bus.ores_id), idx);
    check("prod_valid", 32'(bus.ores_valid), 1);
    check("single_grant", (dut_grants.size() == 1) ? dut_grants[0] : -1, idx);
    rdy_v = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_seq [5];
    rst    = 1'b1;
    vld_v  = '0;
    rdy_v  = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      a_v[k] = 0;
      b_v[k] = 0;
    end
    m_busy = 1'b0;
    m_ptr  = 0;
    cyc    = 0;
    drive();
    @(posedge clk);
    #1;
    check("por_valid", 32'(bus.ores_valid), 0);
    check("por_busy", 32'(bus.obusy), 0);
    check("por_res", 32'(bus.ores), 0);
    rst = 1'b0;

    // Everyone requesting: grant order and spacing
    vld_v = '1;
    for (int k = 0; k < NREQ; k++) begin
      a_v[k] = k + 3;
      b_v[k] = 7 * k + 1;
    end
    dut_grants.delete();
    repeat (15) step();
`ifdef MULT_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    check("rr_count", dut_grants.size(), 5);
    if (dut_grants.size() >= 5)
      for (int i = 0; i < 5; i++) check($sformatf("rr_grant%0d", i), dut_grants[i], exp_seq[i]);

    // Result stall with requests pending
    vld_v = '0;
    wait_idle();
    vld_v = '1;
    rdy_v = 1'b0;
    repeat (8) step();
    rdy_v = 1'b1;
    repeat (4) step();

    // Directed operands
    single(2, 31, 31, 961);
    single(0, 0, 17, 0);
    single(1, 1, 1, 1);
    single(3, 31, 1, 31);

    // Reset during CALC: in-flight job dropped, ptr back to 0
    vld_v = '0;
    wait_idle();
    vld_v    = 4'b0010;
    a_v[1]   = 9;
    b_v[1]   = 9;
    step();
    vld_v = 4'b0110;
    pulse_reset(2);
    dut_grants.delete();
    step();
    check("rearb_count", dut_grants.size(), 1);
    if (dut_grants.size() == 1) check("rearb_grant", dut_grants[0], 1);
    repeat (4) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      vld_v = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        a_v[k] = $urandom_range(0, 31);
        b_v[k] = $urandom_range(0, 31);
      end
      rdy_v = ($urandom_range(0, 3) != 0);
      if (i == 200) pulse_reset(1);
      step();
    end

    vld_v = '0;
    rdy_v = 1'b1;
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
